// File: rtl/gbe_app_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : gbe_app_tx_packetizer
// Description : Application-side UDP packet source for the gbe_udp app TX
//               interface. Serialises a 32-bit valid/ready word stream MSB
//               first into bytes and frames fixed-length packets with eof.
//               An optional 4-byte big-endian sequence number precedes each
//               payload. Counts packets sent and TX FIFO overflow cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module gbe_app_tx_packetizer #(
   parameter int HDR_EN      = 1,
   parameter int PKT_WORDS_W = 8
) (
   input  logic                   app_clk,
   input  logic                   app_rst_n,
   input  logic                   enable,
   input  logic [PKT_WORDS_W-1:0] cfg_pkt_words,
   input  logic [31:0]            cfg_dest_ip,
   input  logic [15:0]            cfg_dest_port,
   input  logic [31:0]            in_data,
   input  logic                   in_vld,
   output logic                   in_rdy,
   output logic [7:0]             app_tx_data,
   output logic                   app_tx_dvld,
   output logic                   app_tx_eof,
   output logic [31:0]            app_tx_destip,
   output logic [15:0]            app_tx_destport,
   input  logic                   app_tx_afull,
   input  logic                   app_tx_overflow,
   output logic                   busy,
   output logic [31:0]            pkt_count,
   output logic [15:0]            ovf_count
);

   // A length field of zero selects the largest packet, one word beyond the
   // field's own range, so the word counters carry one extra bit.
   localparam logic [PKT_WORDS_W:0] c_MAX_WORDS = {1'b1, {PKT_WORDS_W{1'b0}}};
   localparam logic [PKT_WORDS_W:0] c_WCNT_ONE  = {{PKT_WORDS_W{1'b0}}, 1'b1};
   localparam logic                 c_HDR_ON    = (HDR_EN != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_PAY  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [31:0]            r_seq;
   logic [31:0]            r_shift;
   logic                   r_sh_full;
   logic [1:0]             r_bidx;
   logic [PKT_WORDS_W:0]   r_wcnt;
   logic [PKT_WORDS_W:0]   r_len;
   logic                   r_busy;
   logic [31:0]            r_pkt_count;
   logic [15:0]            r_ovf_count;
   logic [7:0]             r_data;
   logic                   r_dvld;
   logic                   r_eof;
   logic [31:0]            r_destip;
   logic [15:0]            r_destport;

   logic                   w_start;
   logic                   w_in_pkt;
   logic                   w_byte_avail;
   logic                   w_issue;
   logic                   w_last_byte;
   logic                   w_words_done;
   logic                   w_word_out;
   logic                   w_in_rdy;
   logic                   w_accept;
   logic                   w_eof;
   logic [31:0]            w_sel_word;
   logic [7:0]             w_byte;
   logic [PKT_WORDS_W:0]   w_cfg_len;

   // ---------------------------------------------------------------------
   // Datapath control terms
   // ---------------------------------------------------------------------
   assign w_start      = (r_state == S_IDLE) & enable & in_vld;
   assign w_in_pkt     = (r_state == S_HDR) | (r_state == S_PAY);
   // Header bytes come from the sequence register and are always ready;
   // payload bytes exist only while the shift register holds a word.
   assign w_byte_avail = (r_state == S_HDR) | ((r_state == S_PAY) & r_sh_full);
   assign w_issue      = w_byte_avail & ~app_tx_afull;
   assign w_last_byte  = (r_bidx == 2'd3);
   assign w_words_done = (r_wcnt == r_len);
   // The held word leaves the shift register on its byte-3 edge, which lets
   // the next word load on the same edge with no bubble.
   assign w_word_out   = (r_state == S_PAY) & w_issue & w_last_byte;
   assign w_in_rdy     = w_in_pkt & ~w_words_done & (~r_sh_full | w_word_out);
   assign w_accept     = in_vld & w_in_rdy;
   // Once every word has been accepted, the word leaving now is the last.
   assign w_eof        = w_word_out & w_words_done;
   assign w_cfg_len    = (cfg_pkt_words == '0) ? c_MAX_WORDS : {1'b0, cfg_pkt_words};

   assign in_rdy          = w_in_rdy;
   assign app_tx_data     = r_data;
   assign app_tx_dvld     = r_dvld;
   assign app_tx_eof      = r_eof;
   assign app_tx_destip   = r_destip;
   assign app_tx_destport = r_destport;
   assign busy            = r_busy;
   assign pkt_count       = r_pkt_count;
   assign ovf_count       = r_ovf_count;

   // Select the byte to issue: header from the sequence number, payload from the shift register.
   always_comb begin
      w_sel_word = r_shift;
      w_byte     = 8'h00;
      if (r_state == S_HDR) begin
         w_sel_word = r_seq;
      end
      case (r_bidx)
         2'd0:    w_byte = w_sel_word[31:24];
         2'd1:    w_byte = w_sel_word[23:16];
         2'd2:    w_byte = w_sel_word[15:8];
         default: w_byte = w_sel_word[7:0];
      endcase
   end

   // Next-state logic for the framing FSM.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = c_HDR_ON ? S_HDR : S_PAY;
            end
         end
         S_HDR: begin
            if (w_issue && w_last_byte) begin
               w_state_nxt = S_PAY;
            end
         end
         S_PAY: begin
            if (w_eof) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge app_clk or negedge app_rst_n) begin
      if (!app_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Byte index, word count and shift register; the index wraps from header byte 3 into payload byte 0.
   always_ff @(posedge app_clk or negedge app_rst_n) begin
      if (!app_rst_n) begin
         r_bidx    <= 2'd0;
         r_wcnt    <= '0;
         r_len     <= '0;
         r_shift   <= 32'h0;
         r_sh_full <= 1'b0;
      end else begin
         if (w_start) begin
            r_bidx <= 2'd0;
            r_wcnt <= '0;
            r_len  <= w_cfg_len;
         end else begin
            if (w_issue) begin
               r_bidx <= r_bidx + 2'd1;
            end
            if (w_accept) begin
               r_wcnt <= r_wcnt + c_WCNT_ONE;
            end
         end
         if (w_accept) begin
            r_shift   <= in_data;
            r_sh_full <= 1'b1;
         end else if (w_word_out) begin
            r_sh_full <= 1'b0;
         end
      end
   end

   // Packet bookkeeping: busy flag, destination latch, sequence and packet counters.
   always_ff @(posedge app_clk or negedge app_rst_n) begin
      if (!app_rst_n) begin
         r_busy      <= 1'b0;
         r_destip    <= 32'h0;
         r_destport  <= 16'h0;
         r_seq       <= 32'h0;
         r_pkt_count <= 32'h0;
      end else begin
         if (w_start) begin
            r_busy     <= 1'b1;
            r_destip   <= cfg_dest_ip;
            r_destport <= cfg_dest_port;
         end else if (w_eof) begin
            r_busy      <= 1'b0;
            r_seq       <= r_seq + 32'd1;
            r_pkt_count <= r_pkt_count + 32'd1;
         end
      end
   end

   // Registered byte interface towards gbe_udp; data holds its last value between bytes.
   always_ff @(posedge app_clk or negedge app_rst_n) begin
      if (!app_rst_n) begin
         r_data <= 8'h00;
         r_dvld <= 1'b0;
         r_eof  <= 1'b0;
      end else begin
         r_dvld <= w_issue;
         r_eof  <= w_eof;
         if (w_issue) begin
            r_data <= w_byte;
         end
      end
   end

   // Saturating count of cycles with the TX FIFO overflow flag raised.
   always_ff @(posedge app_clk or negedge app_rst_n) begin
      if (!app_rst_n) begin
         r_ovf_count <= 16'h0;
      end else if (app_tx_overflow && (r_ovf_count != 16'hFFFF)) begin
         r_ovf_count <= r_ovf_count + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gbe_app_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gbe_app_tx_packetizer
// Description : Directed self-checking bench for gbe_app_tx_packetizer.
//               One instance with the header enabled carries most scenarios;
//               a second instance without header covers the maximum length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gbe_app_tx_packetizer;

   logic        app_clk = 1'b0;
   logic        app_rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  cfg_pkt_words = 8'd0;
   logic [31:0] cfg_dest_ip = 32'h0;
   logic [15:0] cfg_dest_port = 16'h0;
   logic [31:0] in_data = 32'h0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [7:0]  app_tx_data;
   logic        app_tx_dvld;
   logic        app_tx_eof;
   logic [31:0] app_tx_destip;
   logic [15:0] app_tx_destport;
   logic        app_tx_afull = 1'b0;
   logic        app_tx_overflow = 1'b0;
   logic        busy;
   logic [31:0] pkt_count;
   logic [15:0] ovf_count;

   // second instance, no header
   logic        en2 = 1'b0;
   logic [7:0]  cfg2_words = 8'd0;
   logic [31:0] cfg2_ip = 32'h01020304;
   logic [15:0] cfg2_port = 16'h0BAD;
   logic [31:0] in2_data = 32'hA5A5A5A5;
   logic        in2_vld = 1'b1;
   logic        in2_rdy;
   logic [7:0]  d2_data;
   logic        d2_dvld;
   logic        d2_eof;
   logic [31:0] d2_ip;
   logic [15:0] d2_port;
   logic        d2_afull = 1'b0;
   logic        d2_ovf = 1'b0;
   logic        d2_busy;
   logic [31:0] d2_pkt_count;
   logic [15:0] d2_ovf_count;

   always #5 app_clk = ~app_clk;

   gbe_app_tx_packetizer #(.HDR_EN(1), .PKT_WORDS_W(8)) u_dut (
      .app_clk         (app_clk),
      .app_rst_n       (app_rst_n),
      .enable          (enable),
      .cfg_pkt_words   (cfg_pkt_words),
      .cfg_dest_ip     (cfg_dest_ip),
      .cfg_dest_port   (cfg_dest_port),
      .in_data         (in_data),
      .in_vld          (in_vld),
      .in_rdy          (in_rdy),
      .app_tx_data     (app_tx_data),
      .app_tx_dvld     (app_tx_dvld),
      .app_tx_eof      (app_tx_eof),
      .app_tx_destip   (app_tx_destip),
      .app_tx_destport (app_tx_destport),
      .app_tx_afull    (app_tx_afull),
      .app_tx_overflow (app_tx_overflow),
      .busy            (busy),
      .pkt_count       (pkt_count),
      .ovf_count       (ovf_count)
   );

   gbe_app_tx_packetizer #(.HDR_EN(0), .PKT_WORDS_W(8)) u_dut_nohdr (
      .app_clk         (app_clk),
      .app_rst_n       (app_rst_n),
      .enable          (en2),
      .cfg_pkt_words   (cfg2_words),
      .cfg_dest_ip     (cfg2_ip),
      .cfg_dest_port   (cfg2_port),
      .in_data         (in2_data),
      .in_vld          (in2_vld),
      .in_rdy          (in2_rdy),
      .app_tx_data     (d2_data),
      .app_tx_dvld     (d2_dvld),
      .app_tx_eof      (d2_eof),
      .app_tx_destip   (d2_ip),
      .app_tx_destport (d2_port),
      .app_tx_afull    (d2_afull),
      .app_tx_overflow (d2_ovf),
      .busy            (d2_busy),
      .pkt_count       (d2_pkt_count),
      .ovf_count       (d2_ovf_count)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // byte monitor for the main instance
   logic [7:0]  q_d[$];
   bit          q_e[$];
   int          q_t[$];
   logic [31:0] q_ip[$];
   logic [15:0] q_pt[$];
   int          cyc = 0;
   int          n_eof = 0;
   int          n_bad_eof = 0;

   always @(negedge app_clk) begin
      cyc++;
      if (app_tx_dvld) begin
         q_d.push_back(app_tx_data);
         q_e.push_back(app_tx_eof);
         q_t.push_back(cyc);
         q_ip.push_back(app_tx_destip);
         q_pt.push_back(app_tx_destport);
         if (app_tx_eof) n_eof++;
      end
      if (app_tx_eof && !app_tx_dvld) n_bad_eof++;
   end

   // byte monitor for the header-less instance
   int n2_bytes = 0;
   int n2_eof = 0;
   int pos2_eof = 0;
   int n2_bad = 0;

   always @(negedge app_clk) begin
      if (d2_dvld) begin
         n2_bytes++;
         if (d2_data !== 8'hA5) n2_bad++;
         if (d2_eof) begin
            n2_eof++;
            pos2_eof = n2_bytes;
         end
      end
   end

   logic [7:0]  exp_b[$];
   logic [31:0] tx_w[$];

   function automatic void build_exp(input logic [31:0] seq);
      exp_b = {};
      exp_b.push_back(seq[31:24]);
      exp_b.push_back(seq[23:16]);
      exp_b.push_back(seq[15:8]);
      exp_b.push_back(seq[7:0]);
      foreach (tx_w[i]) begin
         exp_b.push_back(tx_w[i][31:24]);
         exp_b.push_back(tx_w[i][23:16]);
         exp_b.push_back(tx_w[i][15:8]);
         exp_b.push_back(tx_w[i][7:0]);
      end
   endfunction

   // Present one word and hold it until a handshake edge; returns at posedge+1.
   task automatic send_word(input logic [31:0] w);
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      in_data = w;
      in_vld  = 1'b1;
      while (!ok && n < 300) begin
         @(negedge app_clk);
         ok = in_rdy;
         @(posedge app_clk);
         #1;
         n++;
      end
      in_vld = 1'b0;
      if (!ok) chk("send_timeout", 64'(n), 64'(0));
   endtask

   task automatic wait_eof(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (n_eof < target && n < budget) begin
         @(posedge app_clk);
         n++;
      end
      #1;
      chk(tag, 64'(n_eof), 64'(target));
   endtask

   task automatic wait_bytes(input int target, input int budget);
      int n;
      n = 0;
      while (q_d.size() < target && n < budget) begin
         @(posedge app_clk);
         n++;
      end
      #1;
      if (q_d.size() < target) chk("byte_wait_timeout", 64'(q_d.size()), 64'(target));
   endtask

   task automatic check_pkt(input string tag, input int base, input logic [31:0] ip,
                            input logic [15:0] pt);
      int n;
      int bad;
      int eofs;
      int ipbad;
      bit last_eof;
      n = q_d.size() - base;
      bad = 0;
      eofs = 0;
      ipbad = 0;
      last_eof = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i >= exp_b.size() || q_d[base+i] !== exp_b[i]) bad++;
         if (q_e[base+i]) eofs++;
         if (q_ip[base+i] !== ip || q_pt[base+i] !== pt) ipbad++;
      end
      if (n > 0) last_eof = q_e[base+n-1];
      chk({tag, "_len"}, 64'(n), 64'(exp_b.size()));
      chk({tag, "_data_errs"}, 64'(bad), 64'(0));
      chk({tag, "_eof_count"}, 64'(eofs), 64'(1));
      chk({tag, "_eof_last"}, 64'(last_eof), 64'(1));
      chk({tag, "_dest_errs"}, 64'(ipbad), 64'(0));
   endtask

   function automatic int gaps(input int base);
      int n;
      n = q_d.size() - base;
      if (n <= 0) return -1;
      return q_t[base+n-1] - q_t[base] + 1 - n;
   endfunction

   initial begin
      int base;
      int n;

      // reset values while reset is held
      repeat (3) @(posedge app_clk);
      #1;
      chk("rst_dvld", 64'(app_tx_dvld), 64'(0));
      chk("rst_eof", 64'(app_tx_eof), 64'(0));
      chk("rst_data", 64'(app_tx_data), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_pkt_count", 64'(pkt_count), 64'(0));
      chk("rst_ovf_count", 64'(ovf_count), 64'(0));
      chk("rst_in_rdy", 64'(in_rdy), 64'(0));
      chk("rst_destip", 64'(app_tx_destip), 64'(0));
      app_rst_n = 1'b1;
      @(posedge app_clk);
      #1;

      // 1: two-word packet, sequence 0, back-to-back bytes
      cfg_pkt_words = 8'd2;
      cfg_dest_ip   = 32'hC0A80001;
      cfg_dest_port = 16'h1234;
      enable        = 1'b1;
      tx_w = '{32'h11223344, 32'h55667788};
      build_exp(32'd0);
      base = q_d.size();
      foreach (tx_w[i]) send_word(tx_w[i]);
      wait_eof(1, 100, "t1_eof_wait");
      check_pkt("t1", base, 32'hC0A80001, 16'h1234);
      chk("t1_gaps", 64'(gaps(base)), 64'(0));
      chk("t1_pkt_count", 64'(pkt_count), 64'(1));
      chk("t1_busy_after", 64'(busy), 64'(0));

      // 2: afull for three edges mid-payload, sequence 1
      tx_w = '{32'hA1A2A3A4, 32'hB1B2B3B4};
      build_exp(32'd1);
      base = q_d.size();
      fork
         begin
            foreach (tx_w[i]) send_word(tx_w[i]);
         end
         begin
            n = 0;
            while (q_d.size() < base + 6 && n < 100) begin
               @(posedge app_clk);
               n++;
            end
            #1;
            app_tx_afull = 1'b1;
            repeat (3) @(posedge app_clk);
            #1;
            app_tx_afull = 1'b0;
         end
      join
      wait_eof(2, 100, "t2_eof_wait");
      check_pkt("t2", base, 32'hC0A80001, 16'h1234);
      chk("t2_gaps", 64'(gaps(base)), 64'(3));
      chk("t2_pkt_count", 64'(pkt_count), 64'(2));

      // 3: starved input between words, cfg changed mid-packet
      cfg_dest_ip   = 32'h0A000001;
      cfg_dest_port = 16'h5555;
      tx_w = '{32'hAABBCCDD, 32'hEEFF0011};
      build_exp(32'd2);
      base = q_d.size();
      send_word(tx_w[0]);
      cfg_dest_ip   = 32'hFFFFFFFF;
      cfg_dest_port = 16'hFFFF;
      cfg_pkt_words = 8'd5;
      repeat (10) @(posedge app_clk);
      #1;
      send_word(tx_w[1]);
      wait_eof(3, 100, "t3_eof_wait");
      check_pkt("t3", base, 32'h0A000001, 16'h5555);
      chk("t3_has_gap", 64'(gaps(base) > 0), 64'(1));
      chk("t3_pkt_count", 64'(pkt_count), 64'(3));

      // 4: enable dropped after the second byte
      cfg_pkt_words = 8'd1;
      cfg_dest_ip   = 32'hC0A80001;
      cfg_dest_port = 16'h1234;
      tx_w = '{32'hDEADBEEF};
      build_exp(32'd3);
      base = q_d.size();
      send_word(tx_w[0]);
      wait_bytes(base + 2, 50);
      enable = 1'b0;
      wait_eof(4, 100, "t4_eof_wait");
      check_pkt("t4", base, 32'hC0A80001, 16'h1234);
      in_data = 32'h12345678;
      in_vld  = 1'b1;
      repeat (20) @(posedge app_clk);
      #1;
      chk("t4_no_restart_busy", 64'(busy), 64'(0));
      chk("t4_no_restart_bytes", 64'(q_d.size() - base), 64'(8));
      chk("t4_in_rdy_idle", 64'(in_rdy), 64'(0));
      chk("t4_pkt_count", 64'(pkt_count), 64'(4));
      in_vld = 1'b0;

      // 5: zero length field means 256 words
      enable        = 1'b1;
      cfg_pkt_words = 8'd0;
      tx_w = {};
      for (int i = 0; i < 256; i++) begin
         logic [7:0] b;
         b = 8'(i);
         tx_w.push_back({b, ~b, b ^ 8'h5A, 8'hC3});
      end
      build_exp(32'd4);
      base = q_d.size();
      foreach (tx_w[i]) send_word(tx_w[i]);
      wait_eof(5, 100, "t5_eof_wait");
      check_pkt("t5", base, 32'hC0A80001, 16'h1234);
      chk("t5_gaps", 64'(gaps(base)), 64'(0));
      chk("t5_pkt_count", 64'(pkt_count), 64'(5));

      en2 = 1'b1;
      n = 0;
      while (!d2_busy && n < 20) begin
         @(posedge app_clk);
         n++;
      end
      #1;
      en2 = 1'b0;
      n = 0;
      while (n2_eof < 1 && n < 1200) begin
         @(posedge app_clk);
         n++;
      end
      repeat (10) @(posedge app_clk);
      #1;
      chk("t5n_bytes", 64'(n2_bytes), 64'(1024));
      chk("t5n_eof_count", 64'(n2_eof), 64'(1));
      chk("t5n_eof_pos", 64'(pos2_eof), 64'(1024));
      chk("t5n_data_errs", 64'(n2_bad), 64'(0));
      chk("t5n_pkt_count", 64'(d2_pkt_count), 64'(1));
      chk("t5n_busy", 64'(d2_busy), 64'(0));

      // 6: overflow counting, mid-packet reset, saturation
      app_tx_overflow = 1'b1;
      repeat (5) @(posedge app_clk);
      #1;
      app_tx_overflow = 1'b0;
      @(posedge app_clk);
      #1;
      chk("t6_ovf_5", 64'(ovf_count), 64'(5));

      cfg_pkt_words = 8'd2;
      base = q_d.size();
      send_word(32'h01020304);
      wait_bytes(base + 6, 50);
      chk("t6_busy_before_rst", 64'(busy), 64'(1));
      @(posedge app_clk);
      #3;
      app_rst_n = 1'b0;
      #1;
      chk("t6_rst_dvld", 64'(app_tx_dvld), 64'(0));
      chk("t6_rst_busy", 64'(busy), 64'(0));
      chk("t6_rst_pkt_count", 64'(pkt_count), 64'(0));
      chk("t6_rst_ovf_count", 64'(ovf_count), 64'(0));
      chk("t6_rst_destip", 64'(app_tx_destip), 64'(0));
      @(posedge app_clk);
      #1;
      app_rst_n = 1'b1;
      @(posedge app_clk);
      #1;
      chk("t6_no_eof_on_abort", 64'(n_eof), 64'(5));

      cfg_pkt_words = 8'd1;
      tx_w = '{32'h0A0B0C0D};
      build_exp(32'd0);
      base = q_d.size();
      send_word(tx_w[0]);
      wait_eof(6, 100, "t6_eof_wait");
      check_pkt("t6", base, 32'hC0A80001, 16'h1234);
      chk("t6_pkt_count", 64'(pkt_count), 64'(1));

      app_tx_overflow = 1'b1;
      repeat (70000) @(posedge app_clk);
      #1;
      app_tx_overflow = 1'b0;
      chk("t6_ovf_sat", 64'(ovf_count), 64'hFFFF);
      chk("eof_without_dvld", 64'(n_bad_eof), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
